// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt front end: FSM states, irq codes,
// and the fixed-priority encoder used to pick the presented source.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_e;

  localparam logic [1:0] IRQ_NONE = 2'b00;
  localparam logic [1:0] IRQ_SRC0 = 2'b01;
  localparam logic [1:0] IRQ_SRC1 = 2'b10;
  localparam logic [1:0] IRQ_SRC2 = 2'b11;

  // Highest set bit wins; only called with a non-zero vector.
  function automatic logic [1:0] prio_idx(input logic [2:0] elig);
    logic [1:0] idx;
    if (elig[2]) begin
      idx = 2'd2;
    end else if (elig[1]) begin
      idx = 2'd1;
    end else begin
      idx = 2'd0;
    end
    return idx;
  endfunction

  function automatic logic [1:0] idx_code(input logic [1:0] idx);
    logic [1:0] code;
    case (idx)
      2'd0:    code = IRQ_SRC0;
      2'd1:    code = IRQ_SRC1;
      default: code = IRQ_SRC2;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for one asynchronous request line, plus rising-edge
// detection on the synchronised value.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic src,
  output logic s,
  output logic e
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Shift the raw line through the chain; remember last synced value
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], src};
    prev_d = s;
  end

  // Synchronous active-low reset clears chain and edge history
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign s = sync_q[SYNC_STAGES-1];
  assign e = s & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt front end: synchronises three request lines, latches them as pending,
// masks and prioritises them, and presents one code until acknowledged.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [2:0] EDGE_MASK   = 3'b111,
  parameter logic [2:0] MASK_RST    = 3'b111,
  parameter int         GAP_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] src,
  input  logic       mask_we,
  input  logic [2:0] mask_din,
  input  logic       irq_ack,
  output logic [1:0] irq,
  output logic [2:0] pending,
  output logic       busy
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [2:0]    s_s, e_s, eligible_s, clr_s;
  logic [2:0]    pending_q, pending_d, mask_q, mask_d;
  logic [1:0]    irq_q, irq_d, sel_q, sel_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          busy_q, busy_d;
  state_e        state_q, state_d;

  for (genvar i = 0; i < 3; i++) begin : g_sync
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .src   (src[i]),
      .s     (s_s[i]),
      .e     (e_s[i])
    );
  end

  // Next-state logic: FSM, gap counter, pending and mask registers
  always_comb begin
    eligible_s = pending_q & mask_q;
    clr_s      = 3'b000;
    state_d    = state_q;
    sel_d      = sel_q;
    irq_d      = irq_q;
    gap_d      = gap_q;
    case (state_q)
      IDLE: begin
        if (eligible_s != 3'b000) begin
          sel_d   = prio_idx(eligible_s);
          irq_d   = idx_code(prio_idx(eligible_s));
          state_d = PRESENT;
        end else begin
          irq_d = IRQ_NONE;
        end
      end
      PRESENT: begin
        // Held until ack; neither priority nor mask changes withdraw it
        if (irq_ack) begin
          clr_s[sel_q] = EDGE_MASK[sel_q];
          irq_d        = IRQ_NONE;
          gap_d        = GW'(GAP_CYCLES - 1);
          state_d      = GAP;
        end else begin
          irq_d = irq_q;
        end
      end
      GAP: begin
        irq_d = IRQ_NONE;
        if (gap_q == GW'(0)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: begin
        irq_d   = IRQ_NONE;
        state_d = IDLE;
      end
    endcase
    // New edge wins over a simultaneous clear; level sources just follow the line
    for (int i = 0; i < 3; i++) begin
      if (EDGE_MASK[i]) begin
        pending_d[i] = e_s[i] | (pending_q[i] & ~clr_s[i]);
      end else begin
        pending_d[i] = s_s[i];
      end
    end
    if (mask_we) begin
      mask_d = mask_din;
    end else begin
      mask_d = mask_q;
    end
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      sel_q     <= 2'd0;
      irq_q     <= IRQ_NONE;
      gap_q     <= '0;
      pending_q <= 3'b000;
      mask_q    <= MASK_RST;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      irq_q     <= irq_d;
      gap_q     <= gap_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      busy_q    <= busy_d;
    end
  end

  assign irq     = irq_q;
  assign pending = pending_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: expected values are queued as stimulus is driven
// and popped when the corresponding DUT output is sampled.
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset, mask_we, irq_ack;
  logic [2:0] src, mask_din;
  logic [1:0] irq, irq2;
  logic [2:0] pending, pending2;
  logic       busy, busy2;

  int checks = 0;
  int errors = 0;

  logic [2:0] exp_q[$];
  string      tag_q[$];

  always #5 clk = ~clk;

  irq_ctrl dut (
    .clk(clk), .reset(reset), .src(src), .mask_we(mask_we), .mask_din(mask_din),
    .irq_ack(irq_ack), .irq(irq), .pending(pending), .busy(busy)
  );

  // Second instance with src[2] configured as a level source
  irq_ctrl #(.EDGE_MASK(3'b011)) dut2 (
    .clk(clk), .reset(reset), .src(src), .mask_we(mask_we), .mask_din(mask_din),
    .irq_ack(irq_ack), .irq(irq2), .pending(pending2), .busy(busy2)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_val(input string tag, input logic [2:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check_val(input logic [2:0] obs);
    logic [2:0] e;
    string      t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  // Ack the presented code on dut and confirm gap then return to idle
  task automatic ack_clear(input string tag);
    irq_ack = 1'b1;
    expect_val({tag, "_ack_irq"}, 3'd0);
    tick(1);
    irq_ack = 1'b0;
    check_val({1'b0, irq});
    expect_val({tag, "_idle_busy"}, 3'd0);
    expect_val({tag, "_idle_pend"}, 3'd0);
    tick(2);
    check_val({2'b00, busy});
    check_val(pending);
  endtask

  task automatic pulse(input logic [2:0] v);
    src = v;
    tick(1);
    src = 3'b000;
  endtask

  initial begin
    reset = 1'b0; src = 3'b101; mask_we = 1'b0; mask_din = 3'b000; irq_ack = 1'b0;

    // 1: reset with requests held, then release
    tick(3);
    expect_val("rst_irq", 3'd0);
    expect_val("rst_pend", 3'd0);
    expect_val("rst_busy", 3'd0);
    check_val({1'b0, irq});
    check_val(pending);
    check_val({2'b00, busy});
    reset = 1'b1;
    expect_val("t1_irq_edge4", 3'd3);
    expect_val("t1_pend", 3'b101);
    expect_val("t1_busy", 3'd1);
    tick(4);
    check_val({1'b0, irq});
    check_val(pending);
    check_val({2'b00, busy});
    src = 3'b000;
    irq_ack = 1'b1;
    expect_val("t1_ack_irq", 3'd0);
    expect_val("t1_ack_pend", 3'b001);
    tick(1);
    irq_ack = 1'b0;
    check_val({1'b0, irq});
    check_val(pending);
    expect_val("t1_gap_irq", 3'd0);
    tick(2);
    check_val({1'b0, irq});
    expect_val("t1_next_irq", 3'd1);
    tick(1);
    check_val({1'b0, irq});
    ack_clear("t1");

    // 2: single edge on src[0], latency and hold without ack
    pulse(3'b001);
    expect_val("t2_lat_k2", 3'd0);
    tick(2);
    check_val({1'b0, irq});
    expect_val("t2_lat_k3", 3'd1);
    tick(1);
    check_val({1'b0, irq});
    expect_val("t2_hold", 3'd1);
    tick(20);
    check_val({1'b0, irq});
    irq_ack = 1'b1;
    expect_val("t2_ack_irq", 3'd0);
    expect_val("t2_ack_pend", 3'd0);
    tick(1);
    irq_ack = 1'b0;
    check_val({1'b0, irq});
    check_val(pending);
    expect_val("t2_gap2_irq", 3'd0);
    tick(1);
    check_val({1'b0, irq});
    expect_val("t2_idle_irq", 3'd0);
    expect_val("t2_idle_busy", 3'd0);
    tick(1);
    check_val({1'b0, irq});
    check_val({2'b00, busy});

    // 3: no preemption by a higher-priority arrival
    pulse(3'b001);
    expect_val("t3_first", 3'd1);
    tick(3);
    check_val({1'b0, irq});
    pulse(3'b100);
    expect_val("t3_nopreempt", 3'd1);
    expect_val("t3_pend", 3'b101);
    tick(5);
    check_val({1'b0, irq});
    check_val(pending);
    irq_ack = 1'b1;
    expect_val("t3_ack_pend", 3'b100);
    tick(1);
    irq_ack = 1'b0;
    check_val(pending);
    expect_val("t3_gap_irq", 3'd0);
    tick(2);
    check_val({1'b0, irq});
    expect_val("t3_second", 3'd3);
    tick(1);
    check_val({1'b0, irq});
    ack_clear("t3");

    // 4: ack on the same edge as a new edge from the presented source
    pulse(3'b001);
    expect_val("t4_first", 3'd1);
    tick(3);
    check_val({1'b0, irq});
    pulse(3'b001);
    tick(1);
    irq_ack = 1'b1;
    expect_val("t4_pend_kept", 3'b001);
    expect_val("t4_ack_irq", 3'd0);
    tick(1);
    irq_ack = 1'b0;
    check_val(pending);
    check_val({1'b0, irq});
    expect_val("t4_gap_irq", 3'd0);
    tick(2);
    check_val({1'b0, irq});
    expect_val("t4_repres", 3'd1);
    tick(1);
    check_val({1'b0, irq});
    ack_clear("t4");

    // 5: masked source latches pending but is not presented
    mask_we = 1'b1;
    mask_din = 3'b110;
    tick(1);
    mask_we = 1'b0;
    pulse(3'b001);
    expect_val("t5_pend", 3'b001);
    expect_val("t5_masked_irq", 3'd0);
    tick(4);
    check_val(pending);
    check_val({1'b0, irq});
    mask_we = 1'b1;
    mask_din = 3'b111;
    expect_val("t5_unmask_w", 3'd0);
    tick(1);
    mask_we = 1'b0;
    check_val({1'b0, irq});
    expect_val("t5_unmask_w1", 3'd1);
    tick(1);
    check_val({1'b0, irq});
    ack_clear("t5");

    // 6: level source on dut2, ack during gap, reset during present
    src = 3'b100;
    expect_val("t6_level", 3'd3);
    tick(4);
    check_val({1'b0, irq2});
    irq_ack = 1'b1;
    expect_val("t6_ack_irq", 3'd0);
    expect_val("t6_ack_pend", 3'b100);
    tick(1);
    check_val({1'b0, irq2});
    check_val(pending2);
    expect_val("t6_gap_ack_irq", 3'd0);
    tick(1);
    irq_ack = 1'b0;
    check_val({1'b0, irq2});
    expect_val("t6_idle_irq", 3'd0);
    expect_val("t6_idle_busy", 3'd0);
    tick(1);
    check_val({1'b0, irq2});
    check_val({2'b00, busy2});
    expect_val("t6_again", 3'd3);
    expect_val("t6_again_busy", 3'd1);
    tick(1);
    check_val({1'b0, irq2});
    check_val({2'b00, busy2});
    reset = 1'b0;
    expect_val("t6_rst_irq", 3'd0);
    expect_val("t6_rst_pend", 3'd0);
    expect_val("t6_rst_busy", 3'd0);
    tick(1);
    check_val({1'b0, irq2});
    check_val(pending2);
    check_val({2'b00, busy2});
    reset = 1'b1;
    src = 3'b000;

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end else begin
      checks++;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
